// File: rtl/lsu_mem_access.sv
// Load/store access unit: decodes funct3, drives byte-lane bus beats (optionally split
// across two words for misaligned accesses) and aligns/extends load data.
module lsu_mem_access #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic [XLEN-1:0]     bus_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    function automatic logic legal_f(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (XLEN == 64);
            3'b100, 3'b101:         ok = ~we;
            3'b110:                 ok = ~we & (XLEN == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Sign bit is the top bit of the kept field; everything above it is filled.
    function automatic logic [XLEN-1:0] extend_f(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] sb;
        logic            sign;
        hi   = {XLEN{1'b1}} << (7'd8 << f3[1:0]);
        sb   = ~hi ^ (~hi >> 1);
        sign = (|(d & sb)) & ~f3[2];
        return sign ? (d | hi) : (d & ~hi);
    endfunction

    state_e              state_q, state_d;
    logic [OB-1:0]       off_q, off_d;
    logic [2:0]          f3_q, f3_d;
    logic                we_q, we_d;
    logic                cross_q, cross_d;
    logic [NB-1:0]       be_hi_q, be_hi_d;
    logic [XLEN-1:0]     wd_hi_q, wd_hi_d;
    logic [XLEN-1:0]     rdata0_q, rdata0_d;
    logic                bus_valid_q, bus_valid_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [NB-1:0]       bus_be_q, bus_be_d;
    logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;

    logic [OB-1:0]       req_off_s;
    logic [OB+1:0]       req_sz_s;
    logic                req_cross_s;
    logic                req_legal_s;
    logic [2*NB-1:0]     be_wide_s;
    logic [2*XLEN-1:0]   wd_wide_s;
    logic [2*XLEN-1:0]   rd_wide_s;
    logic [XLEN-1:0]     load_s;

    assign req_off_s   = req_addr[OB-1:0];
    assign req_sz_s    = (OB+2)'(1'b1) << funct3[1:0];
    assign req_cross_s = (({2'b00, req_off_s} + req_sz_s) > (OB+2)'(NB));
    assign req_legal_s = legal_f(req_we, funct3);
    assign be_wide_s   = (~({(2*NB){1'b1}} << req_sz_s)) << req_off_s;
    assign wd_wide_s   = {{XLEN{1'b0}}, req_wdata} << {req_off_s, 3'b000};

    // The second beat supplies the upper word; a single beat leaves it zero.
    assign rd_wide_s = (state_q == S_BEAT1) ? {bus_rdata, rdata0_q} : {{XLEN{1'b0}}, bus_rdata};
    assign load_s    = extend_f(XLEN'(rd_wide_s >> {off_q, 3'b000}), f3_q);

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        f3_d         = f3_q;
        we_d         = we_q;
        cross_d      = cross_q;
        be_hi_d      = be_hi_q;
        wd_hi_d      = wd_hi_q;
        rdata0_d     = rdata0_q;
        bus_valid_d  = bus_valid_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d   = req_off_s;
                    f3_d    = funct3;
                    we_d    = req_we;
                    cross_d = req_cross_s;
                    be_hi_d = be_wide_s[2*NB-1:NB];
                    wd_hi_d = wd_wide_s[2*XLEN-1:XLEN];
                    if (!req_legal_s || (req_cross_s && !SPLIT_MISALIGNED)) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_BEAT0;
                        bus_valid_d = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
                        bus_be_d    = be_wide_s[NB-1:0];
                        bus_wdata_d = wd_wide_s[XLEN-1:0];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BEAT0: begin
                if (bus_ready) begin
                    rdata0_d = bus_rdata;
                    if (cross_q) begin
                        state_d     = S_BEAT1;
                        bus_addr_d  = bus_addr_q + ADDR_W'(NB);
                        bus_be_d    = be_hi_q;
                        bus_wdata_d = wd_hi_q;
                    end else begin
                        state_d      = S_RESP;
                        bus_valid_d  = 1'b0;
                        bus_we_d     = 1'b0;
                        bus_be_d     = '0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = we_q ? '0 : load_s;
                    end
                end else begin
                    state_d = S_BEAT0;
                end
            end
            S_BEAT1: begin
                if (bus_ready) begin
                    state_d      = S_RESP;
                    bus_valid_d  = 1'b0;
                    bus_we_d     = 1'b0;
                    bus_be_d     = '0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : load_s;
                end else begin
                    state_d = S_BEAT1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any beat in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            off_q        <= '0;
            f3_q         <= 3'b000;
            we_q         <= 1'b0;
            cross_q      <= 1'b0;
            be_hi_q      <= '0;
            wd_hi_q      <= '0;
            rdata0_q     <= '0;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
            cross_q      <= cross_d;
            be_hi_q      <= be_hi_d;
            wd_hi_q      <= wd_hi_d;
            rdata0_q     <= rdata0_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end
endmodule

// File: doc/lsu_mem_access.md
# lsu_mem_access

Parametrised load/store access unit between the execute stage and the memory-mapped data bus. It decodes `funct3` into access size and sign mode, and generates byte enables and lane-shifted write data. For loads it aligns and sign/zero-extends the returned data. Misaligned accesses that straddle a bus word are either split into two bus beats or rejected, selected by parameter. Each transaction uses a valid/ready handshake on both the core side and the bus side.

## Interface
- `XLEN`, 32, data/bus width in bits; 32 or 64 (NB = XLEN/8 bytes, OB = log2(NB) offset bits)
- `ADDR_W`, 32, address width
- `SPLIT_MISALIGNED`, 1, 1 = split word-crossing accesses into two beats; 0 = flag error, no bus access

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in 1: core request valid
- `req_ready` out 1: unit can accept a request; high only in IDLE
- `req_we` in 1: 1 = store, 0 = load
- `funct3` in 3: RISC-V load/store funct3
- `req_addr` in ADDR_W: byte address
- `req_wdata` in XLEN: store data, right-aligned
- `resp_valid` out 1: one-cycle completion pulse
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors
- `resp_err` out 1: misaligned (when SPLIT_MISALIGNED=0) or illegal funct3
- `bus_valid` out 1: bus beat request
- `bus_ready` in 1: beat accepted; `bus_rdata` is sampled in the same cycle
- `bus_we` out 1: beat is a write
- `bus_addr` out ADDR_W: word-aligned address (low OB bits are 0)
- `bus_be` out NB: byte enables
- `bus_wdata` out XLEN: lane-shifted write data
- `bus_rdata` in XLEN: read data

## Operation
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - When XLEN=64, also 011 LD/SD and 110 LWU.
  - All other codes, and any store with funct3[2]=1, are illegal.
- Access size `SZ = 1 << funct3[1:0]` bytes. Offset `OFF = addr[OB-1:0]`. The access crosses a word when `OFF + SZ > NB`.
- A request is captured (addr, we, funct3, wdata) on `req_valid && req_ready`.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE to BEAT0 on capture, if the request is legal and (not crossing or SPLIT_MISALIGNED=1).
  - IDLE to RESP with `resp_err=1` on capture, if illegal, or crossing with SPLIT_MISALIGNED=0. No bus activity occurs.
  - BEAT0 to BEAT1 on `bus_ready` if crossing; otherwise BEAT0 to RESP.
  - BEAT1 to RESP on `bus_ready`.
  - RESP to IDLE unconditionally. `resp_valid` is high for exactly this cycle.
- BEAT0 bus signals:
  - `bus_addr` = addr with low OB bits cleared.
  - `bus_be` = ((1<<SZ)-1) << OFF, truncated to NB.
  - `bus_wdata` = wdata << 8*OFF.
- BEAT1 bus signals:
  - `bus_addr` = BEAT0 address + NB, wrapping modulo 2^ADDR_W.
  - `bus_be` = ((1<<SZ)-1) >> (NB-OFF).
  - `bus_wdata` = wdata >> 8*(NB-OFF).
- Load data path:
  - `bus_rdata` is latched on each beat's handshake.
  - Result = ({beat1, beat0} >> 8*OFF), truncated to SZ bytes.
  - Extension: sign-extended when funct3[2]=0, zero-extended when funct3[2]=1.
- For stores, `bus_we` is 1 on every beat and the read data is ignored.

## Timing
- Reset (async, immediate):
  - State goes to IDLE, so `req_ready=1`.
  - `bus_valid`, `bus_we`, `resp_valid`, `resp_err` = 0.
  - `bus_addr`, `bus_be`, `bus_wdata`, `resp_rdata` = 0.
  - An in-flight beat is abandoned and `bus_valid` drops asynchronously.
- `req_ready` is combinational from state; all other outputs are registered.
- While `bus_valid=1`, `bus_addr`, `bus_be`, `bus_wdata` and `bus_we` are held stable until `bus_ready`. Wait states are unlimited.
- Latency from the capture edge to `resp_valid`, with zero-wait bus:
  - Aligned: 2 cycles.
  - Split: 3 cycles.
  - Error: 1 cycle.
- `resp_rdata` and `resp_err` are valid only while `resp_valid=1`. The earliest next request is accepted in the cycle after RESP.
- `bus_ready` while `bus_valid=0` is ignored.

## Test plan
- Reset, then LW, XLEN=32, addr 0x100, `bus_rdata`=0xDEADBEEF, `bus_ready` tied high:
  - `bus_addr`=0x100, `bus_be`=1111.
  - 2 cycles after capture, `resp_valid` pulses with `resp_rdata`=0xDEADBEEF.
- LB at 0x103 and LBU at 0x103, `bus_rdata`=0x80000000:
  - `bus_be`=1000 for both.
  - LB gives `resp_rdata`=0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x102, wdata=0x0000ABCD:
  - `bus_be`=1100, `bus_wdata`=0xABCD0000, `bus_we`=1.
  - `resp_rdata`=0.
- SPLIT=1, LW at 0x0FE:
  - Beat0: addr 0x0FC, `bus_be`=1100, rdata=0x44332211.
  - Beat1: addr 0x100, `bus_be`=0011, rdata=0x88776655.
  - `resp_rdata`=0x66554433, 3 cycles after capture.
- SPLIT=0, SW at 0x101; and LB with funct3=011 at XLEN=32:
  - Neither raises `bus_valid`.
  - Each gives `resp_valid` and `resp_err`=1 one cycle after capture.
- LW with `bus_ready` held low for 5 cycles, then `rst` asserted:
  - `bus_addr` is stable throughout.
  - After `rst`, `bus_valid` is 0 immediately, no `resp_valid` occurs, and `req_ready`=1.
